// File: rtl/keycode_event_tracker_if.sv
// Keycode event tracker bus: SoC snapshot input, event stream output and status.
// master = SoC/consumer side, slave = tracker side.
interface keycode_event_tracker_if #(
   parameter int N_CH  = 4,
   parameter int KW    = 8,
   parameter int DEPTH = 8
);
   logic [N_CH*KW-1:0]      keycode_export;
   logic                    kc_valid;
   logic                    ev_valid;
   logic                    ev_ready;
   logic [KW-1:0]           ev_code;
   logic                    ev_press;
   logic [$clog2(DEPTH):0]  fifo_level;
   logic                    held_any;
   logic                    drop;
   logic                    drop_clr;

   modport master (
      output keycode_export, kc_valid, ev_ready, drop_clr,
      input  ev_valid, ev_code, ev_press, fifo_level, held_any, drop
   );

   modport slave (
      input  keycode_export, kc_valid, ev_ready, drop_clr,
      output ev_valid, ev_code, ev_press, fifo_level, held_any, drop
   );
endinterface

// File: rtl/keycode_event_tracker.sv
// Keycode event tracker: diffs successive keycode snapshots into press/release
// events delivered through a first-word-fall-through FIFO.
// Optional macro KEYTRK_ROLLOVER_FILTER_EN: discard snapshots containing 0x01
// (HID ErrorRollOver) at IDLE.
//
// state    | meaning
// ---------+--------------------------------------------------------------
// IDLE     | wait for a new or pending snapshot, load it into cur
// SCAN_REL | walk prev slots, emit release for codes missing from cur
// SCAN_PRS | walk cur slots, emit press for codes missing from prev
// COMMIT   | prev <= cur
module keycode_event_tracker #(
   parameter int N_CH  = 4,
   parameter int KW    = 8,
   parameter int DEPTH = 8
) (
   input logic                    clk_clk,
   input logic                    reset_reset_n,
   keycode_event_tracker_if.slave bus
);
   localparam int IW = (N_CH > 1) ? $clog2(N_CH) : 1;
   localparam int AW = $clog2(DEPTH);
   localparam int LW = AW + 1;
   localparam int SW = N_CH * KW;

   typedef enum logic [1:0] {S_IDLE, S_SCAN_REL, S_SCAN_PRS, S_COMMIT} state_t;

   state_t          r_state, w_state_nxt;
   logic [SW-1:0]   r_prev, r_cur, r_pend;
   logic            r_pend_v;
   logic [IW-1:0]   r_idx;
   logic            r_drop;
   logic [KW:0]     r_mem [DEPTH];
   logic [AW-1:0]   r_wptr, r_rptr;
   logic [LW-1:0]   r_level;

   logic [KW-1:0]   w_own   [N_CH];
   logic [KW-1:0]   w_other [N_CH];
   logic [KW-1:0]   w_code;
   logic            w_in_other, w_dup_lower;
   logic            w_scanning, w_emit, w_push, w_stall, w_last, w_press;
   logic            w_full, w_pop, w_valid;
   logic [SW-1:0]   w_src;
   logic            w_rollover, w_load, w_accept, w_drop_set;

   assign w_valid    = (r_level != '0);
   assign w_full     = (r_level == LW'(DEPTH));
   assign w_pop      = w_valid && bus.ev_ready;
   assign w_drop_set = bus.kc_valid && r_pend_v;

   // Orient slots for the scan direction: own = snapshot being walked, other = compared against
   always_comb begin
      for (int i = 0; i < N_CH; i++) begin
         if (r_state == S_SCAN_PRS) begin
            w_own[i]   = r_cur[i*KW +: KW];
            w_other[i] = r_prev[i*KW +: KW];
         end else begin
            w_own[i]   = r_prev[i*KW +: KW];
            w_other[i] = r_cur[i*KW +: KW];
         end
      end
   end

   // Slot under idx: present in the other snapshot, or already seen at a lower slot
   always_comb begin
      w_code      = '0;
      w_in_other  = 1'b0;
      w_dup_lower = 1'b0;
      for (int i = 0; i < N_CH; i++)
         if (IW'(i) == r_idx) w_code = w_own[i];
      for (int i = 0; i < N_CH; i++) begin
         if (w_other[i] == w_code) w_in_other = 1'b1;
         if ((IW'(i) < r_idx) && (w_own[i] == w_code)) w_dup_lower = 1'b1;
      end
   end

   // Snapshot source at IDLE and optional rollover rejection
   always_comb begin
      w_src      = bus.kc_valid ? bus.keycode_export : r_pend;
      w_rollover = 1'b0;
`ifdef KEYTRK_ROLLOVER_FILTER_EN
      for (int i = 0; i < N_CH; i++)
         if (w_src[i*KW +: KW] == KW'(1)) w_rollover = 1'b1;
`endif
      w_load   = bus.kc_valid || r_pend_v;
      w_accept = w_load && !w_rollover;
   end

   // FSM state register
   always_ff @(posedge clk_clk) begin
      if (!reset_reset_n) r_state <= S_IDLE;
      else                r_state <= w_state_nxt;
   end

   // FSM next-state; a stalled slot holds the state
   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         S_IDLE:     if (w_accept)           w_state_nxt = S_SCAN_REL;
         S_SCAN_REL: if (!w_stall && w_last) w_state_nxt = S_SCAN_PRS;
         S_SCAN_PRS: if (!w_stall && w_last) w_state_nxt = S_COMMIT;
         S_COMMIT:                           w_state_nxt = S_IDLE;
         default:                            w_state_nxt = S_IDLE;
      endcase
   end

   // FSM outputs: event emission, FIFO push and stall
   always_comb begin
      w_scanning = (r_state == S_SCAN_REL) || (r_state == S_SCAN_PRS);
      w_emit     = w_scanning && (w_code != '0) && !w_in_other && !w_dup_lower;
      w_push     = w_emit && (!w_full || w_pop);
      w_stall    = w_emit && !w_push;
      w_last     = (r_idx == IW'(N_CH - 1));
      w_press    = (r_state == S_SCAN_PRS);
   end

   // Snapshot registers, pending slot, slot index and sticky drop flag
   always_ff @(posedge clk_clk) begin
      if (!reset_reset_n) begin
         r_prev   <= '0;
         r_cur    <= '0;
         r_pend   <= '0;
         r_pend_v <= 1'b0;
         r_idx    <= '0;
         r_drop   <= 1'b0;
      end else begin
         if (r_state == S_IDLE) begin
            if (w_load) begin
               r_cur    <= w_src;
               r_pend_v <= 1'b0;
            end
            r_idx <= '0;
         end else begin
            if (bus.kc_valid) begin
               r_pend   <= bus.keycode_export;
               r_pend_v <= 1'b1;
            end
            if (w_scanning && !w_stall)
               r_idx <= w_last ? '0 : r_idx + IW'(1);
         end
         if (r_state == S_COMMIT) r_prev <= r_cur;
         if (w_drop_set)        r_drop <= 1'b1;
         else if (bus.drop_clr) r_drop <= 1'b0;
      end
   end

   // FIFO pointers and level
   always_ff @(posedge clk_clk) begin
      if (!reset_reset_n) begin
         r_wptr  <= '0;
         r_rptr  <= '0;
         r_level <= '0;
      end else begin
         if (w_push) r_wptr <= r_wptr + AW'(1);
         if (w_pop)  r_rptr <= r_rptr + AW'(1);
         if (w_push && !w_pop)      r_level <= r_level + LW'(1);
         else if (!w_push && w_pop) r_level <= r_level - LW'(1);
      end
   end

   // FIFO storage; contents are masked on the outputs while empty
   always_ff @(posedge clk_clk) begin
      if (w_push) r_mem[r_wptr] <= {w_press, w_code};
   end

   assign bus.ev_valid   = w_valid;
   assign bus.ev_code    = w_valid ? r_mem[r_rptr][KW-1:0] : '0;
   assign bus.ev_press   = w_valid ? r_mem[r_rptr][KW] : 1'b0;
   assign bus.fifo_level = r_level;
   assign bus.held_any   = |r_prev;
   assign bus.drop       = r_drop;
endmodule

// File: tb/tb_keycode_event_tracker.sv
// Bench for keycode_event_tracker: directed scenarios plus random snapshots
// checked against a set-based diff model of press/release events.
module tb_keycode_event_tracker;
   localparam int N_CH  = 4;
   localparam int KW    = 8;
   localparam int DEPTH = 2;
   localparam int SW    = N_CH * KW;

   logic clk_clk = 1'b0;
   logic reset_reset_n;
   int   n_vec = 0;
   int   n_err = 0;
   int   lat;

   logic [SW-1:0] m_prev;
   logic [KW:0]   exp_q [$];
   logic [KW:0]   got_q [$];
   logic [KW-1:0] pool  [8];
   logic [SW-1:0] snap;

   keycode_event_tracker_if #(.N_CH(N_CH), .KW(KW), .DEPTH(DEPTH)) bus ();

   keycode_event_tracker #(.N_CH(N_CH), .KW(KW), .DEPTH(DEPTH)) dut (
      .clk_clk       (clk_clk),
      .reset_reset_n (reset_reset_n),
      .bus           (bus)
   );

   always #5 clk_clk = ~clk_clk;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_vec++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   function automatic logic [SW-1:0] mk(input logic [KW-1:0] s0, input logic [KW-1:0] s1,
                                        input logic [KW-1:0] s2, input logic [KW-1:0] s3);
      return {s3, s2, s1, s0};
   endfunction

   function automatic logic [KW-1:0] slot(input logic [SW-1:0] s, input int i);
      return s[i*KW +: KW];
   endfunction

   // One clock; records the head event if it is being accepted this cycle
   task automatic step();
      if (bus.ev_valid && bus.ev_ready) got_q.push_back({bus.ev_press, bus.ev_code});
      @(posedge clk_clk);
      #1;
   endtask

   task automatic drain(input int n, input bit rnd);
      for (int k = 0; k < n; k++) begin
         bus.ev_ready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
         step();
      end
   endtask

   // Expected events: distinct codes leaving the held set (in prev order), then
   // distinct codes entering it (in new order)
   task automatic model_apply(input logic [SW-1:0] s);
      bit in_new [256];
      bit in_old [256];
      bit done   [256];
`ifdef KEYTRK_ROLLOVER_FILTER_EN
      bit roll;
      roll = 1'b0;
      for (int i = 0; i < N_CH; i++) if (slot(s, i) == 8'h01) roll = 1'b1;
      if (roll) return;
`endif
      for (int k = 0; k < 256; k++) begin
         in_new[k] = 1'b0;
         in_old[k] = 1'b0;
         done[k]   = 1'b0;
      end
      for (int i = 0; i < N_CH; i++) begin
         in_new[slot(s, i)]      = 1'b1;
         in_old[slot(m_prev, i)] = 1'b1;
      end
      for (int i = 0; i < N_CH; i++)
         if (slot(m_prev, i) != 0 && !in_new[slot(m_prev, i)] && !done[slot(m_prev, i)]) begin
            exp_q.push_back({1'b0, slot(m_prev, i)});
            done[slot(m_prev, i)] = 1'b1;
         end
      for (int k = 0; k < 256; k++) done[k] = 1'b0;
      for (int i = 0; i < N_CH; i++)
         if (slot(s, i) != 0 && !in_old[slot(s, i)] && !done[slot(s, i)]) begin
            exp_q.push_back({1'b1, slot(s, i)});
            done[slot(s, i)] = 1'b1;
         end
      m_prev = s;
   endtask

   task automatic apply(input logic [SW-1:0] s);
      bus.keycode_export = s;
      bus.kc_valid       = 1'b1;
      step();
      bus.kc_valid       = 1'b0;
      model_apply(s);
   endtask

   task automatic check_events(input string tag);
      chk({tag, " count"}, 64'(got_q.size()), 64'(exp_q.size()));
      for (int k = 0; k < exp_q.size() && k < got_q.size(); k++)
         chk({tag, " event"}, 64'(got_q[k]), 64'(exp_q[k]));
      got_q.delete();
      exp_q.delete();
   endtask

   task automatic chk_reset_outputs(input string tag);
      chk({tag, " ev_valid"},   64'(bus.ev_valid),   64'd0);
      chk({tag, " ev_code"},    64'(bus.ev_code),    64'd0);
      chk({tag, " ev_press"},   64'(bus.ev_press),   64'd0);
      chk({tag, " fifo_level"}, 64'(bus.fifo_level), 64'd0);
      chk({tag, " held_any"},   64'(bus.held_any),   64'd0);
      chk({tag, " drop"},       64'(bus.drop),       64'd0);
   endtask

   initial begin
      pool[0] = 8'h00; pool[1] = 8'h00; pool[2] = 8'h04; pool[3] = 8'h05;
      pool[4] = 8'h06; pool[5] = 8'h1A; pool[6] = 8'h2C; pool[7] = 8'h01;
      reset_reset_n      = 1'b0;
      bus.keycode_export = '0;
      bus.kc_valid       = 1'b0;
      bus.ev_ready       = 1'b0;
      bus.drop_clr       = 1'b0;
      m_prev             = '0;
      repeat (3) step();
      chk_reset_outputs("reset");
      reset_reset_n = 1'b1;
      step();

      // Single press: slot 0 press evaluated N_CH+1 cycles after the strobe edge,
      // visible one edge later; held_any after COMMIT at 2*N_CH+1
      bus.ev_ready = 1'b0;
      apply(mk(8'h04, 8'h00, 8'h00, 8'h00));
      lat = 0;
      while (!bus.ev_valid && lat < 20) begin
         step();
         lat++;
      end
      chk("press latency", 64'(lat), 64'(N_CH + 1));
      chk("press level", 64'(bus.fifo_level), 64'd1);
      repeat (N_CH - 1) step();
      chk("held_any before commit", 64'(bus.held_any), 64'd0);
      step();
      chk("held_any after commit", 64'(bus.held_any), 64'd1);
      drain(10, 1'b0);
      check_events("press");

      // Swap {04,1A} -> {1A,16}
      apply(mk(8'h04, 8'h1A, 8'h00, 8'h00));
      drain(20, 1'b0);
      check_events("swap setup");
      apply(mk(8'h1A, 8'h16, 8'h00, 8'h00));
      drain(20, 1'b0);
      chk("swap first", got_q.size() > 0 ? 64'(got_q[0]) : '1, 64'({1'b0, 8'h04}));
      chk("swap second", got_q.size() > 1 ? 64'(got_q[1]) : '1, 64'({1'b1, 8'h16}));
      check_events("swap");

      apply('0);
      drain(20, 1'b0);
      check_events("clear");

      // Duplicates with a full FIFO and no consumer
      bus.ev_ready = 1'b0;
      apply(mk(8'h2C, 8'h2C, 8'h05, 8'h06));
      repeat (20) step();
      chk("stall level", 64'(bus.fifo_level), 64'(DEPTH));
      chk("stall no commit", 64'(bus.held_any), 64'd0);
      chk("stall head code", 64'(bus.ev_code), 64'h2C);
      chk("stall head press", 64'(bus.ev_press), 64'd1);
      drain(20, 1'b0);
      check_events("stall");

      // Three strobes back to back; middle one is overwritten. drop_clr in the
      // same cycle as the set must lose.
      bus.ev_ready       = 1'b1;
      bus.keycode_export = mk(8'h04, 8'h00, 8'h00, 8'h00);
      bus.kc_valid       = 1'b1;
      step();
      bus.keycode_export = mk(8'h07, 8'h00, 8'h00, 8'h00);
      step();
      bus.keycode_export = mk(8'h08, 8'h09, 8'h00, 8'h00);
      bus.drop_clr       = 1'b1;
      step();
      bus.kc_valid = 1'b0;
      bus.drop_clr = 1'b0;
      model_apply(mk(8'h04, 8'h00, 8'h00, 8'h00));
      model_apply(mk(8'h08, 8'h09, 8'h00, 8'h00));
      chk("drop set", 64'(bus.drop), 64'd1);
      drain(40, 1'b0);
      check_events("pending");
      chk("drop sticky", 64'(bus.drop), 64'd1);
      bus.drop_clr = 1'b1;
      step();
      bus.drop_clr = 1'b0;
      chk("drop cleared", 64'(bus.drop), 64'd0);

      // ErrorRollOver snapshot, then a follow-up that reveals prev
      apply(mk(8'h01, 8'h01, 8'h01, 8'h01));
      drain(20, 1'b0);
      check_events("rollover");
      apply(mk(8'h04, 8'h00, 8'h00, 8'h00));
      drain(20, 1'b0);
      check_events("after rollover");

      // Reset in SCAN_PRS with events queued
      bus.ev_ready = 1'b0;
      apply(mk(8'h05, 8'h06, 8'h00, 8'h00));
      repeat (N_CH + 1) step();
      chk("midscan queued", 64'(bus.ev_valid), 64'd1);
      reset_reset_n = 1'b0;
      step();
      chk_reset_outputs("midscan reset");
      reset_reset_n = 1'b1;
      m_prev = '0;
      exp_q.delete();
      got_q.delete();
      step();

      for (int it = 0; it < 40; it++) begin
         for (int i = 0; i < N_CH; i++) snap[i*KW +: KW] = pool[$urandom_range(0, 7)];
         apply(snap);
         drain(30, 1'b1);
         drain(15, 1'b0);
         check_events("random");
         chk("random held_any", 64'(bus.held_any), 64'(m_prev != '0));
         chk("random level", 64'(bus.fifo_level), 64'd0);
      end

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end
endmodule
